// File: rtl/seg7_scan_ctrl.sv
// 4-digit hex display scan controller with a two-client round-robin update arbiter.
// Define SEG7_LZB_EN to blank leading-zero digits; otherwise every digit shows seg_in.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  req,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    output logic [1:0]  gnt,
    input  logic [6:0]  seg_in,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [15:0] x_shown
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    logic [CW-1:0] cnt;
    logic [1:0]    d;
    logic          tick;
    logic          frame_wrap;
    logic          state;
    logic          rr;
    logic          sel;
    logic [15:0]   pbuf;
    logic          blank;

    assign tick       = (cnt == CNT_MAX);
    assign frame_wrap = tick && (d == 2'd3);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
            d   <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            d   <= d + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // With both clients requesting, rr picks; a lone requester always wins.
    assign sel = (req == 2'b11) ? rr : req[1];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_IDLE;
            gnt     <= 2'b00;
            rr      <= 1'b0;
            pbuf    <= 16'h0000;
            x_shown <= 16'h0000;
        end else begin
            gnt <= 2'b00;
            if (state == ST_IDLE) begin
                // gnt still high means the client has not yet dropped req
                if (gnt == 2'b00 && req != 2'b00) begin
                    pbuf  <= sel ? din1 : din0;
                    gnt   <= sel ? 2'b10 : 2'b01;
                    rr    <= ~sel;
                    state <= ST_PEND;
                end
            end else if (frame_wrap) begin
                x_shown <= pbuf;
                state   <= ST_IDLE;
            end
        end
    end

    assign an  = ~(4'b0001 << d);
    assign nib = x_shown[{d, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    always_comb begin
        blank = 1'b0;
        case (d)
            2'd1:    blank = (x_shown[15:4] == 12'h000);
            2'd2:    blank = (x_shown[15:8] == 8'h00);
            2'd3:    blank = (x_shown[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign seg = blank ? 7'h7F : seg_in;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues expected grants/commits,
// a negedge monitor pops and compares them; scan outputs are checked against a phase model.
module tb_seg7_scan_ctrl;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        r0 = 1'b0;
    logic        r1 = 1'b0;
    logic [15:0] din0 = 16'h0000;
    logic [15:0] din1 = 16'h0000;
    logic [6:0]  seg_in = 7'h2A;
    logic [1:0]  gnt;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] x_shown;

    int nvec = 0;
    int nerr = 0;
    int ph = 0;
    int cyc = 0;
    int gnt_cyc = 0;

    logic [1:0]  exp_gnt[$];
    logic [15:0] exp_commit[$];
    logic [15:0] prev_x = 16'h0000;
    logic [3:0]  prev_an = 4'b1110;

    seg7_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .clk(clk), .clr(clr), .req({r1, r0}), .din0(din0), .din1(din1),
        .gnt(gnt), .seg_in(seg_in), .nib(nib), .an(an), .seg(seg), .x_shown(x_shown)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Phase since reset release: the expected digit is (ph/SD)%4.
    initial forever begin
        @(posedge clk or posedge clr);
        if (clr) ph = 0;
        else ph++;
        if (!clr) cyc++;
    end

    // Monitor: grants and commits are popped from the scoreboard as they appear.
    initial forever begin
        @(negedge clk);
        if (clr) begin
            prev_x  = x_shown;
            prev_an = an;
        end else begin
            if (gnt != 2'b00) begin
                if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'(0));
                else chk("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
                gnt_cyc = cyc;
            end
            if (x_shown !== prev_x) begin
                if (exp_commit.size() == 0) chk("commit_unexpected", 32'(x_shown), 32'(prev_x));
                else chk("commit", 32'(x_shown), 32'(exp_commit.pop_front()));
                chk("commit_frame", 32'({prev_an, an}), 32'({4'b0111, 4'b1110}));
                chk("commit_lat", 32'((cyc - gnt_cyc) <= 4 * SD), 32'(1));
            end
            prev_x  = x_shown;
            prev_an = an;
        end
    end

    task automatic client(input int i, input logic [15:0] v, output int lat);
        lat = 0;
        if (i == 0) begin din0 = v; r0 = 1'b1; end
        else begin din1 = v; r1 = 1'b1; end
        do begin
            @(negedge clk);
            lat++;
        end while (gnt[i] !== 1'b1 && lat < 300);
        if (gnt[i] !== 1'b1) chk("gnt_wait", 32'(gnt[i]), 32'(1));
        if (i == 0) r0 = 1'b0;
        else r1 = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_gnt.size() + exp_commit.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_gnt.size() + exp_commit.size()), 32'(0));
        exp_gnt.delete();
        exp_commit.delete();
    endtask

    task automatic check_scan(input logic [15:0] xv, input int n);
        int dd;
        logic [15:0] sh;
        logic [3:0] ea;
        logic bl;
        logic [6:0] se;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            seg_in = 7'($urandom);
            #1;
            dd = (ph / SD) % 4;
            sh = xv >> (4 * dd);
            ea = ~(4'b0001 << dd);
            bl = 1'b0;
`ifdef SEG7_LZB_EN
            bl = (dd != 0) && (sh == 16'h0000);
`endif
            se = bl ? 7'h7F : seg_in;
            chk("an", 32'(an), 32'(ea));
            chk("nib", 32'(nib), 32'(sh[3:0]));
            chk("seg", 32'(seg), 32'(se));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, n;
        #1;
        chk("rst_an", 32'(an), 32'(4'b1110));
        chk("rst_x", 32'(x_shown), 32'(0));
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_nib", 32'(nib), 32'(0));
        chk("rst_seg", 32'(seg), 32'(7'h2A));
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;

        // Zero value scan: first tick 4 cycles after release, then a full frame and a bit
        check_scan(16'h0000, 20);

        // Contention with rr=0: client 0 first
        exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b10);
        exp_commit.push_back(16'h1111); exp_commit.push_back(16'h2222);
        fork
            client(0, 16'h1111, l0);
            client(1, 16'h2222, l1);
        join
        chk("lat_c0_first", 32'(l0), 32'(1));
        wait_drain();

        // Single request; leaves rr pointing at client 1
        exp_gnt.push_back(2'b01);
        exp_commit.push_back(16'h00A5);
        client(0, 16'h00A5, l0);
        chk("lat_single", 32'(l0), 32'(1));
        wait_drain();
        check_scan(16'h00A5, 16);

        // Contention with rr=1: client 1 first
        exp_gnt.push_back(2'b10); exp_gnt.push_back(2'b01);
        exp_commit.push_back(16'h4444); exp_commit.push_back(16'h3005);
        fork
            client(0, 16'h3005, l0);
            client(1, 16'h4444, l1);
        join
        chk("lat_c1_first", 32'(l1), 32'(1));
        wait_drain();
        check_scan(16'h3005, 16);

        // Reset mid-PEND: align to just after a frame start so no commit occurs first
        n = 0;
        while ((ph % 16) != 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp_gnt.push_back(2'b01);
        client(0, 16'hBEEF, l0);
        chk("lat_beef", 32'(l0), 32'(1));
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("midrst_an", 32'(an), 32'(4'b1110));
        chk("midrst_x", 32'(x_shown), 32'(0));
        chk("midrst_nib", 32'(nib), 32'(0));
        chk("midrst_gnt", 32'(gnt), 32'(0));
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        exp_gnt.push_back(2'b01);
        exp_commit.push_back(16'h1234);
        client(0, 16'h1234, l0);
        chk("lat_after_rst", 32'(l0), 32'(1));
        wait_drain();
        check_scan(16'h1234, 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
